// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package counter_pkg;

    localparam logic CNT_DN   = 1'b0;
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Largest value representable in 'width' bits, kept within 32 bits.
    function automatic int unsigned cnt_default_max(input int unsigned width);
        if (width >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: step up or down within 0..MAX_VAL,
// reporting whether the step wrapped or was blocked by saturation.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'(cnt_default_max(WIDTH))
) (
    input  logic [WIDTH-1:0] out,
    input  logic             updn,
    input  logic             sat,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap_evt,
    output logic             sat_evt
);

    // Boundaries are explicit compares against MAX_VAL so non-power-of-two
    // moduli behave the same as full-range ones.
    always_comb begin
        next_val = out;
        wrap_evt = 1'b0;
        sat_evt  = 1'b0;
        if (updn == CNT_UP) begin
            if (out < MAX_VAL) begin
                next_val = out + 1'b1;
            end else if (sat == CNT_SAT) begin
                sat_evt = 1'b1;
            end else begin
                next_val = '0;
                wrap_evt = 1'b1;
            end
        end else begin
            if (out != '0) begin
                next_val = out - 1'b1;
            end else if (sat == CNT_SAT) begin
                sat_evt = 1'b1;
            end else begin
                next_val = MAX_VAL;
                wrap_evt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_updn_param.sv
// Parametrised up/down counter with load, terminal flags and wrap pulse.
// Define COUNTER_SAT_EN to add the per-cycle 'sat' mode input and live 'sat_hit'.
module counter_updn_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = cnt_default_max(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic             sat_mode;
    logic [WIDTH-1:0] next_val;
    logic             wrap_evt;
    logic             sat_evt;

`ifdef COUNTER_SAT_EN
    assign sat_mode = sat;
`else
    // Constant wrap mode lets synthesis drop the saturation path and sat_hit flop.
    assign sat_mode = CNT_WRAP;
`endif

    counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_V)
    ) u_next (
        .out      (out),
        .updn     (updn),
        .sat      (sat_mode),
        .next_val (next_val),
        .wrap_evt (wrap_evt),
        .sat_evt  (sat_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (load) begin
            out     <= (load_val > MAX_V) ? MAX_V : load_val;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (en) begin
            out     <= next_val;
            wrap    <= wrap_evt;
            sat_hit <= sat_evt;
        end else begin
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end
    end

    assign at_max = (out == MAX_V);
    assign at_min = (out == '0);

endmodule
